// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if
//   One Avalon-style memory link. The same bundle is used for each requester
//   port of the arbiter and for the shared slave bus.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid/error
//   slave  modport : the opposite direction
interface mips_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid, error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, error
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Two-requester arbiter for the single memory bus of mips_cpu_bus.
//   m0 = data port (load/store), m1 = instruction fetch. One transfer in
//   flight at a time; read data is routed back to the owner and a transfer
//   the slave stalls for TIMEOUT cycles is aborted with an error pulse.
// Ports
//   clk    : clock, all state on posedge
//   reset  : asynchronous, active low
//   m0, m1 : requester links (slave modport)
//   bus    : shared slave link (master modport); readdatavalid/error unused
// Parameters
//   AW, DW  : address / data width (byteenable = DW/8)
//   TIMEOUT : max stalled cycles before abort, 0 disables
//   RR      : 1 = round-robin on tie, 0 = fixed priority m0
module mips_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int RR      = 1
) (
    input  logic                clk,
    input  logic                reset,
    mips_bus_arbiter_if.slave   m0,
    mips_bus_arbiter_if.slave   m1,
    mips_bus_arbiter_if.master  bus
);
    // Keep at least one count bit so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    state_t          r_state, w_next;
    logic            r_owner, w_owner_nxt;   // 0 = m0, 1 = m1
    logic            r_last,  w_last_nxt;    // last requester served
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [1:0]      r_rdv,   w_rdv;
    logic [1:0]      r_err,   w_err;
    logic [DW-1:0]   r_rdata0, r_rdata1;

    logic            w_req0, w_req1, w_pick;
    logic            w_own_rd, w_own_wr;
    logic [AW-1:0]   w_own_addr;
    logic [DW-1:0]   w_own_wd;
    logic [DW/8-1:0] w_own_be;
    logic            w_wait0, w_wait1;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    // Tie goes to whoever was not served last (RR) or always to m0.
    assign w_pick = (w_req0 && w_req1) ? ((RR != 0) ? ~r_last : 1'b0) : w_req1;

    // Owner's request; a simultaneous read+write is treated as a write.
    assign w_own_wr   = r_owner ? m1.write : m0.write;
    assign w_own_rd   = (r_owner ? m1.read : m0.read) & ~w_own_wr;
    assign w_own_addr = r_owner ? m1.address    : m0.address;
    assign w_own_wd   = r_owner ? m1.writedata  : m0.writedata;
    assign w_own_be   = r_owner ? m1.byteenable : m0.byteenable;

    // Stall counter saturates instead of wrapping.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_rdv    <= '0;
            r_err    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdv   <= w_rdv;
            r_err   <= w_err;
            if (w_rdv[0]) r_rdata0 <= bus.readdata;
            if (w_rdv[1]) r_rdata1 <= bus.readdata;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_rdv          = '0;
        w_err          = '0;
        w_wait0        = 1'b1;
        w_wait1        = 1'b1;
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_next      = S_XFER;
                end
            end
            S_XFER: begin
                bus.address    = w_own_addr;
                bus.read       = w_own_rd;
                bus.write      = w_own_wr;
                bus.writedata  = w_own_wd;
                bus.byteenable = w_own_be;
                if (r_owner) w_wait1 = bus.waitrequest;
                else         w_wait0 = bus.waitrequest;
                if (!(w_own_rd || w_own_wr)) begin
                    // Requester withdrew before acceptance: no error, no credit.
                    w_next = S_IDLE;
                end else if (!bus.waitrequest) begin
                    w_last_nxt = r_owner;
                    w_next     = w_own_wr ? S_IDLE : S_RDATA;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if ((TIMEOUT != 0) && (w_cnt_inc >= TO_VAL)) begin
                        w_err[r_owner] = 1'b1;
                        w_last_nxt     = r_owner;
                        w_next         = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                // Slave returns data this cycle; capture it for the owner.
                w_rdv[r_owner] = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign m0.waitrequest   = w_wait0;
    assign m1.waitrequest   = w_wait1;
    assign m0.readdata      = r_rdata0;
    assign m1.readdata      = r_rdata1;
    assign m0.readdatavalid = r_rdv[0];
    assign m1.readdatavalid = r_rdv[1];
    assign m0.error         = r_err[0];
    assign m1.error         = r_err[1];
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter. Two instances share clock and reset:
//   inst 0 : RR=1, TIMEOUT=4
//   inst 1 : RR=0, TIMEOUT=0 (timeout disabled)
// Each has its own requester drive arrays and a one-cycle-latency slave.
module tb_mips_bus_arbiter;
    logic clk;
    logic rst_n;

    logic [31:0] d_addr [2][2];
    logic        d_rd   [2][2];
    logic        d_wr   [2][2];
    logic [31:0] d_wd   [2][2];
    logic [3:0]  d_be   [2][2];
    logic        s_wait [2];

    logic        o_wait  [2][2];
    logic        o_rdv   [2][2];
    logic        o_err   [2][2];
    logic [31:0] o_rdata [2][2];
    logic [31:0] b_addr  [2];
    logic [31:0] b_wd    [2];
    logic [3:0]  b_be    [2];
    logic        b_rd    [2];
    logic        b_wr    [2];

    int n_cmp;
    int n_bad;

    typedef struct {
        int          p;
        logic [31:0] d;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C08_BFC0 : (a ^ 32'hDEAD_BEEF);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mips_bus_arbiter_if #(.AW(32), .DW(32)) m0 ();
            mips_bus_arbiter_if #(.AW(32), .DW(32)) m1 ();
            mips_bus_arbiter_if #(.AW(32), .DW(32)) bus ();
            logic [31:0] r_sdata = '0;

            assign m0.address    = d_addr[gi][0];
            assign m0.read       = d_rd[gi][0];
            assign m0.write      = d_wr[gi][0];
            assign m0.writedata  = d_wd[gi][0];
            assign m0.byteenable = d_be[gi][0];
            assign m1.address    = d_addr[gi][1];
            assign m1.read       = d_rd[gi][1];
            assign m1.write      = d_wr[gi][1];
            assign m1.writedata  = d_wd[gi][1];
            assign m1.byteenable = d_be[gi][1];

            assign bus.waitrequest   = s_wait[gi];
            assign bus.readdata      = r_sdata;
            assign bus.readdatavalid = 1'b0;
            assign bus.error         = 1'b0;

            always @(posedge clk)
                if (bus.read && !bus.waitrequest) r_sdata <= mem_f(bus.address);

            assign o_wait[gi][0]  = m0.waitrequest;
            assign o_wait[gi][1]  = m1.waitrequest;
            assign o_rdv[gi][0]   = m0.readdatavalid;
            assign o_rdv[gi][1]   = m1.readdatavalid;
            assign o_err[gi][0]   = m0.error;
            assign o_err[gi][1]   = m1.error;
            assign o_rdata[gi][0] = m0.readdata;
            assign o_rdata[gi][1] = m1.readdata;
            assign b_addr[gi]     = bus.address;
            assign b_wd[gi]       = bus.writedata;
            assign b_be[gi]       = bus.byteenable;
            assign b_rd[gi]       = bus.read;
            assign b_wr[gi]       = bus.write;

            mips_bus_arbiter #(
                .AW(32), .DW(32),
                .TIMEOUT((gi == 0) ? 4 : 0),
                .RR((gi == 0) ? 1 : 0)
            ) u_dut (
                .clk  (clk),
                .reset(rst_n),
                .m0   (m0),
                .m1   (m1),
                .bus  (bus)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int i, input int p, input logic [31:0] a);
        exp_t e;
        e.p = p;
        e.d = mem_f(a);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic sb_pop(input int i, input int p, input logic [31:0] d);
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : q1.size();
        n_cmp++;
        assert (sz != 0) else begin
            n_bad++;
            $error("FAIL rdv_unexpected: inst %0d port %0d got pulse data %0h want no pulse", i, p, d);
        end
        if (sz != 0) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("rdv_port", 32'(p), 32'(e.p));
            chk("rdv_data", d, e.d);
        end
    endtask

    // Scoreboard consumer: every readdatavalid pulse must match a queued read.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (o_rdv[i][p] === 1'b1) sb_pop(i, p, o_rdata[i][p]);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Both requesters read continuously; log the first three grants.
    task automatic t3(input int i, input logic [2:0] exp);
        int         ng;
        logic [2:0] got;
        ng  = 0;
        got = '0;
        nxt();
        d_addr[i][0] = 32'h100;
        d_addr[i][1] = 32'h200;
        d_rd[i][0]   = 1'b1;
        d_rd[i][1]   = 1'b1;
        s_wait[i]    = 1'b0;
        for (int c = 0; c < 30 && ng < 3; c++) begin
            smp();
            for (int p = 0; p < 2; p++)
                if (ng < 3 && d_rd[i][p] && !o_wait[i][p]) begin
                    got[ng] = p[0];
                    ng++;
                    sb_push(i, p, d_addr[i][p]);
                end
            nxt();
        end
        d_rd[i][0] = 1'b0;
        d_rd[i][1] = 1'b0;
        chk("t3_ngrant", 32'(ng), 32'd3);
        chk("t3_order", 32'(got), 32'(exp));
        repeat (3) begin smp(); nxt(); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_wait[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                d_addr[i][p] = '0; d_rd[i][p] = 1'b0; d_wr[i][p] = 1'b0;
                d_wd[i][p] = '0;   d_be[i][p] = '0;
            end
        end

        // T1: reset state, during and after reset
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd", 32'(b_rd[i]), 32'd0);
            chk("rst_wr", 32'(b_wr[i]), 32'd0);
            chk("rst_addr", b_addr[i], 32'd0);
            chk("rst_wait0", 32'(o_wait[i][0]), 32'd1);
            chk("rst_wait1", 32'(o_wait[i][1]), 32'd1);
            chk("rst_rdv1", 32'(o_rdv[i][1]), 32'd0);
            chk("rst_err0", 32'(o_err[i][0]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
        for (int i = 0; i < 2; i++) begin
            chk("t1_rd", 32'(b_rd[i]), 32'd0);
            chk("t1_wait0", 32'(o_wait[i][0]), 32'd1);
            chk("t1_rdata0", o_rdata[i][0], 32'd0);
        end

        // T2: m1 fetch, zero-wait slave
        nxt();
        d_rd[0][1] = 1'b1; d_addr[0][1] = 32'hBFC0_0000; s_wait[0] = 1'b0;
        smp();
        chk("t2_c0_wait1", 32'(o_wait[0][1]), 32'd1);
        chk("t2_c0_rd", 32'(b_rd[0]), 32'd0);
        nxt(); smp();
        chk("t2_c1_rd", 32'(b_rd[0]), 32'd1);
        chk("t2_c1_addr", b_addr[0], 32'hBFC0_0000);
        chk("t2_c1_wait1", 32'(o_wait[0][1]), 32'd0);
        chk("t2_c1_wait0", 32'(o_wait[0][0]), 32'd1);
        sb_push(0, 1, 32'hBFC0_0000);
        nxt(); d_rd[0][1] = 1'b0; smp();
        chk("t2_c2_rd", 32'(b_rd[0]), 32'd0);
        chk("t2_c2_rdv", 32'(o_rdv[0][1]), 32'd0);
        nxt(); smp();
        chk("t2_c3_rdv", 32'(o_rdv[0][1]), 32'd1);
        chk("t2_c3_rdata", o_rdata[0][1], 32'h3C08_BFC0);
        nxt(); smp();
        chk("t2_c4_rdv", 32'(o_rdv[0][1]), 32'd0);
        chk("t2_c4_hold", o_rdata[0][1], 32'h3C08_BFC0);

        // T3: tie arbitration, round-robin vs fixed priority
        t3(0, 3'b010);
        t3(1, 3'b000);

        // T4: m0 write with 3 stall cycles
        nxt();
        d_wr[0][0] = 1'b1; d_addr[0][0] = 32'hBFC0_0018;
        d_wd[0][0] = 32'h73; d_be[0][0] = 4'hF; s_wait[0] = 1'b1;
        smp();
        chk("t4_idle_wr", 32'(b_wr[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            nxt(); smp();
            chk("t4_stall_wr", 32'(b_wr[0]), 32'd1);
            chk("t4_stall_addr", b_addr[0], 32'hBFC0_0018);
            chk("t4_stall_wd", b_wd[0], 32'h73);
            chk("t4_stall_be", 32'(b_be[0]), 32'hF);
            chk("t4_stall_wait", 32'(o_wait[0][0]), 32'd1);
        end
        nxt(); s_wait[0] = 1'b0; smp();
        chk("t4_accept_wait", 32'(o_wait[0][0]), 32'd0);
        chk("t4_accept_wr", 32'(b_wr[0]), 32'd1);
        nxt(); d_wr[0][0] = 1'b0; smp();
        chk("t4_after_wr", 32'(b_wr[0]), 32'd0);
        chk("t4_after_err", 32'(o_err[0][0]), 32'd0);

        // T5: timeout abort (TIMEOUT=4), pending m1 then served
        nxt();
        d_wr[0][0] = 1'b1; d_addr[0][0] = 32'h40; d_wd[0][0] = 32'h1; s_wait[0] = 1'b1;
        smp();
        nxt();
        d_rd[0][1] = 1'b1; d_addr[0][1] = 32'h300;
        smp();
        chk("t5_holdoff_m1", 32'(o_wait[0][1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            nxt(); smp();
            chk("t5_stall_wr", 32'(b_wr[0]), 32'd1);
            chk("t5_stall_err", 32'(o_err[0][0]), 32'd0);
        end
        nxt(); s_wait[0] = 1'b0; smp();
        chk("t5_abort_wr", 32'(b_wr[0]), 32'd0);
        chk("t5_abort_rd", 32'(b_rd[0]), 32'd0);
        chk("t5_err0", 32'(o_err[0][0]), 32'd1);
        chk("t5_err1", 32'(o_err[0][1]), 32'd0);
        nxt(); d_wr[0][0] = 1'b0; smp();
        chk("t5_err0_once", 32'(o_err[0][0]), 32'd0);
        chk("t5_m1_rd", 32'(b_rd[0]), 32'd1);
        chk("t5_m1_addr", b_addr[0], 32'h300);
        chk("t5_m1_wait", 32'(o_wait[0][1]), 32'd0);
        sb_push(0, 1, 32'h300);
        nxt(); d_rd[0][1] = 1'b0; smp();
        nxt(); smp();
        chk("t5_m1_rdv", 32'(o_rdv[0][1]), 32'd1);

        // T6: reset during m1 XFER
        nxt();
        d_rd[0][1] = 1'b1; d_addr[0][1] = 32'h500; s_wait[0] = 1'b1;
        nxt(); smp();
        chk("t6_xfer_rd", 32'(b_rd[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rd", 32'(b_rd[0]), 32'd0);
        chk("t6_rst_wait", 32'(o_wait[0][1]), 32'd1);
        d_rd[0][1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk("t6_no_rdv", 32'(o_rdv[0][1]), 32'd0);
            nxt();
        end
        d_rd[0][1] = 1'b1; s_wait[0] = 1'b0;
        smp();
        nxt(); smp();
        chk("t6_re_wait", 32'(o_wait[0][1]), 32'd0);
        sb_push(0, 1, 32'h500);
        nxt(); d_rd[0][1] = 1'b0; smp();
        nxt(); smp();
        chk("t6_re_rdv", 32'(o_rdv[0][1]), 32'd1);
        chk("t6_re_rdata", o_rdata[0][1], mem_f(32'h500));

        // T7: read+write together -> write wins
        nxt();
        d_rd[0][1] = 1'b1; d_wr[0][1] = 1'b1; d_addr[0][1] = 32'h600; d_wd[0][1] = 32'hAB;
        smp();
        nxt(); smp();
        chk("t7_wr", 32'(b_wr[0]), 32'd1);
        chk("t7_rd_forced0", 32'(b_rd[0]), 32'd0);
        nxt(); d_rd[0][1] = 1'b0; d_wr[0][1] = 1'b0; smp();
        nxt(); smp();
        chk("t7_no_rdv", 32'(o_rdv[0][1]), 32'd0);

        // T8: TIMEOUT=0 never aborts
        nxt();
        d_wr[1][0] = 1'b1; d_addr[1][0] = 32'h700; s_wait[1] = 1'b1;
        smp();
        for (int k = 0; k < 6; k++) begin
            nxt(); smp();
            chk("t8_stall_wr", 32'(b_wr[1]), 32'd1);
            chk("t8_no_err", 32'(o_err[1][0]), 32'd0);
        end
        nxt(); s_wait[1] = 1'b0; smp();
        chk("t8_accept", 32'(o_wait[1][0]), 32'd0);
        nxt(); d_wr[1][0] = 1'b0; smp();
        chk("t8_after_err", 32'(o_err[1][0]), 32'd0);

        nxt(); smp();
        chk("sb_drain0", 32'(q0.size()), 32'd0);
        chk("sb_drain1", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
